// File: rtl/sd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : sd_pkg                                                     |
// | Description : Shared types and constants for the SD sector buffer        |
// |               controller: FSM state encoding, default sector size and    |
// |               the fixed 9-bit buffer address type.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package sd_pkg;

  // Default sector buffer size in bytes.
  localparam int SECTOR_BYTES = 512;

  // Buffer byte-address width; fixed, independent of SECTOR_BYTES.
  localparam int BUF_AW = 9;

  typedef logic [BUF_AW-1:0] buf_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FILL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage : sd_pkg
`default_nettype wire

// File: rtl/sd_buf_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : sd_buf_ctrl_if                                             |
// | Description : Bundles every non-clock/reset signal of sd_buf_ctrl.       |
// |   Command   : start, sector -> busy, done, err                           |
// |   SD reader : sd_req, sd_sector -> ; <- sd_ack, sd_err                   |
// |   Word in   : in_valid, in_data -> ; <- in_ready                         |
// |   Buffer RAM: ram_we, ram_waddr, ram_wdata, ram_raddr -> ; <- ram_rdata  |
// |   Byte out  : out_valid, out_data -> ; <- out_ready                      |
// |   master = controller side, slave = environment side.                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface sd_buf_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  import sd_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] sector;
  logic              busy;
  logic              done;
  logic              err;

  logic              sd_req;
  logic [ADDR_W-1:0] sd_sector;
  logic              sd_ack;
  logic              sd_err;

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;

  logic              ram_we;
  buf_addr_t         ram_waddr;
  logic [15:0]       ram_wdata;
  buf_addr_t         ram_raddr;
  logic [7:0]        ram_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;

  modport master (
    input  start, sector, sd_ack, sd_err, in_valid, in_data, ram_rdata, out_ready,
    output busy, done, err, sd_req, sd_sector, in_ready,
           ram_we, ram_waddr, ram_wdata, ram_raddr, out_valid, out_data
  );

  modport slave (
    output start, sector, sd_ack, sd_err, in_valid, in_data, ram_rdata, out_ready,
    input  busy, done, err, sd_req, sd_sector, in_ready,
           ram_we, ram_waddr, ram_wdata, ram_raddr, out_valid, out_data
  );

endinterface : sd_buf_ctrl_if
`default_nettype wire

// File: rtl/sd_buf_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sd_buf_ctrl                                                |
// | Description : Fetches one sector from an SD reader into an external      |
// |               byte buffer (16-bit writes, big-endian byte order within   |
// |               a word) and then streams it out one byte per handshake.    |
// | Ports       : clk  - sole clock, rising edge                             |
// |               rst  - asynchronous active-high reset                      |
// |               bus  - sd_buf_ctrl_if.master (command, SD reader, word     |
// |                      input, buffer RAM and byte output signals)          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sd_buf_ctrl #(
  parameter int SECTOR_BYTES = sd_pkg::SECTOR_BYTES,
  parameter int ADDR_W       = 32
) (
  input  wire logic     clk,
  input  wire logic     rst,
  sd_buf_ctrl_if.master bus
);
  import sd_pkg::*;

  localparam buf_addr_t C_LAST_WADDR = buf_addr_t'(SECTOR_BYTES - 2);
  localparam buf_addr_t C_LAST_RADDR = buf_addr_t'(SECTOR_BYTES - 1);
  localparam buf_addr_t C_WORD_STEP  = buf_addr_t'(2);
  localparam buf_addr_t C_BYTE_STEP  = buf_addr_t'(1);

  state_t            r_state;
  buf_addr_t         r_waddr;
  buf_addr_t         r_raddr;
  logic [ADDR_W-1:0] r_sector;
  logic              r_busy;
  logic              r_sd_req;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_done;
  logic              r_err;

  // r_in_ready is only ever high in FILL, so it doubles as the FILL qualifier.
  // An sd_err in the same cycle kills the word so nothing reaches the buffer.
  logic w_in_fire;
  logic w_out_fire;
  assign w_in_fire  = bus.in_valid && r_in_ready && !bus.sd_err;
  assign w_out_fire = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_sector    <= '0;
      r_busy      <= 1'b0;
      r_sd_req    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sector <= bus.sector;
            r_state  <= ST_REQ;
            r_busy   <= 1'b1;
            r_sd_req <= 1'b1;
          end
        end

        ST_REQ: begin
          // Error wins over a simultaneous acknowledge.
          if (bus.sd_err) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_sd_req <= 1'b0;
            r_err    <= 1'b1;
          end else if (bus.sd_ack) begin
            r_state    <= ST_FILL;
            r_sd_req   <= 1'b0;
            r_in_ready <= 1'b1;
            r_waddr    <= '0;
          end
        end

        ST_FILL: begin
          if (bus.sd_err) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            r_err      <= 1'b1;
          end else if (w_in_fire) begin
            // Natural 9-bit wrap takes the last word address back to 0.
            r_waddr <= r_waddr + C_WORD_STEP;
            if (r_waddr == C_LAST_WADDR) begin
              r_state     <= ST_DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_raddr     <= '0;
            end
          end
        end

        ST_DRAIN: begin
          if (w_out_fire) begin
            r_raddr <= r_raddr + C_BYTE_STEP;
            if (r_raddr == C_LAST_RADDR) begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_sd_req    <= 1'b0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.sd_req    = r_sd_req;
  assign bus.sd_sector = r_sector;
  assign bus.in_ready  = r_in_ready;
  assign bus.ram_we    = w_in_fire;
  assign bus.ram_waddr = r_waddr;
  assign bus.ram_wdata = bus.in_data;
  assign bus.ram_raddr = r_raddr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = bus.ram_rdata;

endmodule : sd_buf_ctrl
`default_nettype wire

// File: tb/tb_sd_buf_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sd_buf_ctrl                                             |
// | Description : Directed self-checking bench for sd_buf_ctrl with a        |
// |               behavioural byte RAM and a negedge bus monitor.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sd_buf_ctrl;
  import sd_pkg::*;

  localparam int C_ADDR_W = 32;
  localparam int C_BYTES  = 512;
  localparam int C_WORDS  = C_BYTES / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_buf_ctrl_if #(.ADDR_W(C_ADDR_W)) bus ();

  sd_buf_ctrl #(
    .SECTOR_BYTES(C_BYTES),
    .ADDR_W      (C_ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural buffer RAM: 16-bit write, combinational byte read.
  logic [7:0] mem [0:C_BYTES-1];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_waddr]        <= bus.ram_wdata[15:8];
      mem[bus.ram_waddr + 9'd1] <= bus.ram_wdata[7:0];
    end
  end
  assign bus.ram_rdata = mem[bus.ram_raddr];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor, sampled mid-cycle while inputs are stable.
  int          n_done   = 0;
  int          n_err    = 0;
  int          n_we     = 0;
  int          n_we_err = 0;
  int          n_inrdy  = 0;
  int          n_ov     = 0;
  int          n_badsec = 0;
  int          out_idx  = 0;
  logic [31:0] exp_sector;
  logic [7:0]  got [0:C_BYTES-1];

  always @(negedge clk) begin
    if (rst) begin
      out_idx <= 0;
    end else begin
      if (bus.start && !bus.busy)              out_idx  <= 0;
      if (bus.done)                            n_done   <= n_done + 1;
      if (bus.err)                             n_err    <= n_err + 1;
      if (bus.ram_we)                          n_we     <= n_we + 1;
      if (bus.ram_we && bus.sd_err)            n_we_err <= n_we_err + 1;
      if (bus.in_ready)                        n_inrdy  <= n_inrdy + 1;
      if (bus.out_valid)                       n_ov     <= n_ov + 1;
      if (bus.sd_req && bus.sd_sector !== exp_sector) n_badsec <= n_badsec + 1;
      if (bus.out_valid && bus.out_ready) begin
        if (out_idx < C_BYTES) got[out_idx] <= bus.out_data;
        out_idx <= out_idx + 1;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int a);
    logic [7:0] k;
    k = 8'(a / 2);
    return (a % 2 == 1) ? ~k : k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] sec);
    bus.sector = sec;
    bus.start  = 1'b1;
    exp_sector = sec;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic do_req(input int dly, input logic with_err);
    repeat (dly) tick();
    bus.sd_ack = 1'b1;
    bus.sd_err = with_err;
    tick();
    bus.sd_ack = 1'b0;
    bus.sd_err = 1'b0;
  endtask

  // Sends words k -> {k, ~k} with periodic valid gaps; optionally raises
  // sd_err alongside word err_word, optionally pulses start mid-fill.
  task automatic do_fill(input int err_word, input bit poke, output int sent);
    int  w;
    int  cyc;
    bit  gap;
    bit  rdy;
    bit  errd;
    w   = 0;
    cyc = 0;
    while (w < C_WORDS && cyc < 4 * C_WORDS) begin
      gap          = (cyc % 7) == 3;
      bus.in_valid = !gap;
      bus.in_data  = {8'(w), ~8'(w)};
      errd         = !gap && (w == err_word);
      bus.sd_err   = errd;
      bus.start    = poke && (cyc == 40);
      bus.sector   = 32'hDEAD_BEEF;
      rdy          = bus.in_ready;
      tick();
      bus.start    = 1'b0;
      bus.sd_err   = 1'b0;
      if (errd) begin
        bus.in_valid = 1'b0;
        sent = w;
        return;
      end
      if (!gap && rdy) w++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    sent = w;
  endtask

  // Drains until 512 bytes are seen; mode 1 toggles out_ready.
  // A non-negative rst_at asserts reset once that many bytes are out.
  task automatic do_drain(input int mode, input bit poke, input int rst_at);
    int cyc;
    cyc = 0;
    while (out_idx < C_BYTES && cyc < 4 * C_BYTES) begin
      if (rst_at >= 0 && out_idx == rst_at) begin
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_busy",      bus.busy,      0);
        check_val("rst_done",      bus.done,      0);
        check_val("rst_in_ready",  bus.in_ready,  0);
        check_val("rst_sd_sector", bus.sd_sector, 0);
        return;
      end
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      bus.start     = poke && (cyc == 100);
      tick();
      bus.start     = 1'b0;
      cyc++;
    end
    bus.out_ready = 1'b0;
    check_val("drain_count", out_idx, C_BYTES);
    check_val("done_pulse",  bus.done, 1);
    check_val("done_busy",   bus.busy, 0);
  endtask

  task automatic check_bytes();
    int bad;
    bad = 0;
    for (int i = 0; i < C_BYTES; i++)
      if (got[i] !== exp_byte(i)) bad++;
    check_val("bytes_bad", bad,       0);
    check_val("byte0",     got[0],    8'h00);
    check_val("byte1",     got[1],    8'hFF);
    check_val("byte2",     got[2],    8'h01);
    check_val("byte3",     got[3],    8'hFE);
    check_val("byte511",   got[511],  8'h00);
  endtask

  // Complete start -> fetch -> drain run with the usual end checks.
  task automatic full_run(input logic [31:0] sec, input int dly, input int mode, input bit poke);
    int sent;
    int b_done;
    int b_err;
    int b_we;
    b_done = n_done;
    b_err  = n_err;
    b_we   = n_we;
    do_start(sec);
    check_val("req_sd_req",    bus.sd_req,    1);
    check_val("req_busy",      bus.busy,      1);
    check_val("req_sd_sector", bus.sd_sector, sec);
    do_req(dly, 1'b0);
    check_val("fill_in_ready", bus.in_ready,  1);
    check_val("fill_sd_req",   bus.sd_req,    0);
    do_fill(-1, poke, sent);
    check_val("fill_words",    sent,          C_WORDS);
    check_val("first_valid",   bus.out_valid, 1);
    check_val("first_data",    bus.out_data,  8'h00);
    check_val("drain_in_rdy",  bus.in_ready,  0);
    do_drain(mode, poke, -1);
    check_bytes();
    tick();
    check_val("done_cleared",  bus.done,      0);
    check_val("done_count",    n_done - b_done, 1);
    check_val("err_count",     n_err - b_err,   0);
    check_val("we_count",      n_we - b_we,     C_WORDS);
    check_val("sector_held",   bus.sd_sector,   sec);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int b_err;
    int b_we;
    int b_wee;
    int b_ov;
    int b_rdy;
    int b_done;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.sector    = '0;
    bus.sd_ack    = 1'b0;
    bus.sd_err    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    exp_sector    = '0;
    repeat (3) tick();
    check_val("reset_busy",      bus.busy,      0);
    check_val("reset_done",      bus.done,      0);
    check_val("reset_err",       bus.err,       0);
    check_val("reset_sd_req",    bus.sd_req,    0);
    check_val("reset_in_ready",  bus.in_ready,  0);
    check_val("reset_ram_we",    bus.ram_we,    0);
    check_val("reset_out_valid", bus.out_valid, 0);
    check_val("reset_sd_sector", bus.sd_sector, 0);
    rst = 1'b0;
    tick();

    // Basic sector, ack after three cycles, back-to-back consumer.
    full_run(32'h0000_1234, 3, 0, 1'b0);

    // Throttled consumer with extra start pulses during FILL and DRAIN.
    full_run(32'h00AB_CDEF, 0, 1, 1'b1);
    repeat (4) tick();
    check_val("no_refetch_busy", bus.busy,   0);
    check_val("no_refetch_req",  bus.sd_req, 0);

    // sd_err on word 100 of FILL.
    b_err = n_err; b_we = n_we; b_wee = n_we_err; b_ov = n_ov;
    do_start(32'h0000_0077);
    do_req(1, 1'b0);
    do_fill(100, 1'b0, sent);
    check_val("ferr_sent",      sent,               100);
    check_val("ferr_pulse",     bus.err,            1);
    check_val("ferr_busy",      bus.busy,           0);
    check_val("ferr_in_ready",  bus.in_ready,       0);
    tick();
    check_val("ferr_cleared",   bus.err,            0);
    repeat (3) tick();
    check_val("ferr_we_count",  n_we - b_we,        100);
    check_val("ferr_we_in_err", n_we_err - b_wee,   0);
    check_val("ferr_no_out",    n_ov - b_ov,        0);
    check_val("ferr_err_count", n_err - b_err,      1);

    // sd_err together with sd_ack in REQ.
    b_err = n_err; b_rdy = n_inrdy;
    do_start(32'h0000_0099);
    do_req(2, 1'b1);
    check_val("rerr_pulse",     bus.err,            1);
    check_val("rerr_busy",      bus.busy,           0);
    check_val("rerr_sd_req",    bus.sd_req,         0);
    repeat (3) tick();
    check_val("rerr_no_fill",   n_inrdy - b_rdy,    0);
    check_val("rerr_err_count", n_err - b_err,      1);

    // Reset at byte 300 of DRAIN, then a fresh sector.
    b_done = n_done; b_err = n_err;
    do_start(32'h0000_0300);
    do_req(1, 1'b0);
    do_fill(-1, 1'b0, sent);
    check_val("rdr_fill_words", sent,               C_WORDS);
    do_drain(0, 1'b0, 300);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_val("rdr_no_done",    n_done - b_done,    0);
    check_val("rdr_no_err",     n_err - b_err,      0);
    full_run(32'h0000_5A5A, 1, 0, 1'b0);

    check_val("sector_mismatch_cycles", n_badsec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_sd_buf_ctrl
`default_nettype wire
